// File: rtl/eq2_vec_seq.sv
`default_nettype none
// ============================================================================
// Module   : eq2_vec_seq
// Purpose  : Drives all 16 (a,b) vectors into an eq2 comparator, waits a
//            programmable settle time, checks aeqb and counts mismatches.
//            Macro EQ2_SEQ_STOP_ON_ERR_EN ends the run at the first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module eq2_vec_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [1:0] a,
    output logic [1:0] b,
    input  logic       aeqb,
    output logic       busy,
    output logic       done_tick,
    output logic [3:0] vec_idx,
    output logic [4:0] err_cnt,
    output logic       pass
);

    localparam int               CNT_W        = 8;
    localparam logic [CNT_W-1:0] c_DWELL_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       c_LAST_VEC   = 4'd15;
    localparam logic [4:0]       c_ERR_MAX    = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_vec_idx;
    logic [3:0]       w_vec_idx_next;
    logic [4:0]       r_err_cnt;
    logic [4:0]       w_err_cnt_next;
    logic [CNT_W-1:0] r_dwell;
    logic [CNT_W-1:0] w_dwell_next;
    logic             r_pass;
    logic             w_pass_next;
    logic [1:0]       r_a;
    logic [1:0]       r_b;
    logic             r_busy;
    logic             r_done_tick;

    logic             w_mismatch;
    logic [4:0]       w_err_inc;
    logic             w_run_end;

    assign w_mismatch = (aeqb != (r_a == r_b));
    assign w_err_inc  = (r_err_cnt == c_ERR_MAX) ? r_err_cnt : r_err_cnt + 5'd1;

`ifdef EQ2_SEQ_STOP_ON_ERR_EN
    assign w_run_end = w_mismatch || (r_vec_idx == c_LAST_VEC);
`else
    assign w_run_end = (r_vec_idx == c_LAST_VEC);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_vec_idx_next = r_vec_idx;
        w_err_cnt_next = r_err_cnt;
        w_dwell_next   = r_dwell;
        w_pass_next    = r_pass;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_vec_idx_next = 4'd0;
                    w_err_cnt_next = 5'd0;
                    w_pass_next    = 1'b0;
                    w_dwell_next   = c_DWELL_LOAD;
                    w_state_next   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_dwell == '0) begin
                    w_state_next = S_CHECK;
                end else begin
                    w_dwell_next = r_dwell - 1'b1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    w_err_cnt_next = w_err_inc;
                end
                if (w_run_end) begin
                    // pass is captured with the final count so it is valid alongside done_tick
                    w_pass_next  = (w_err_cnt_next == 5'd0);
                    w_state_next = S_DONE;
                end else begin
                    w_vec_idx_next = r_vec_idx + 4'd1;
                    w_dwell_next   = c_DWELL_LOAD;
                    w_state_next   = S_SETTLE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // busy/done_tick are registered from the next state so they align with a/b
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec_idx   <= 4'd0;
            r_err_cnt   <= 5'd0;
            r_dwell     <= '0;
            r_pass      <= 1'b0;
            r_a         <= 2'd0;
            r_b         <= 2'd0;
            r_busy      <= 1'b0;
            r_done_tick <= 1'b0;
        end else begin
            r_vec_idx   <= w_vec_idx_next;
            r_err_cnt   <= w_err_cnt_next;
            r_dwell     <= w_dwell_next;
            r_pass      <= w_pass_next;
            r_a         <= w_vec_idx_next[3:2];
            r_b         <= w_vec_idx_next[1:0];
            r_busy      <= (w_state_next == S_SETTLE) || (w_state_next == S_CHECK);
            r_done_tick <= (w_state_next == S_DONE);
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done_tick = r_done_tick;
    assign vec_idx   = r_vec_idx;
    assign err_cnt   = r_err_cnt;
    assign pass      = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_eq2_vec_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_eq2_vec_seq
// Purpose  : Self-checking bench for eq2_vec_seq with a fault-injecting eq2 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eq2_vec_seq;

    localparam int S    = 4;
    localparam int MAXC = 16 * (S + 1) + 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        aeqb;
    logic        busy;
    logic        done_tick;
    logic [3:0]  vec_idx;
    logic [4:0]  err_cnt;
    logic        pass;
    logic [15:0] fault_mask;

    int n_checks = 0;
    int n_pass   = 0;

    // per-cycle trace of one run, indexed by cycle number (start edge = cycle 0)
    logic [3:0] tr_vec  [0:MAXC];
    logic [1:0] tr_a    [0:MAXC];
    logic [1:0] tr_b    [0:MAXC];
    logic       tr_busy [0:MAXC];
    logic       tr_dt   [0:MAXC];
    logic [4:0] tr_err  [0:MAXC];
    logic       tr_pass [0:MAXC];
    int         run_done;

    int exp_err;
    int exp_last;
    int exp_done;

    always #5 clk = ~clk;

    // eq2 stand-in: a set mask bit inverts the comparator answer for that vector
    assign aeqb = (a == b) ^ fault_mask[{a, b}];

    eq2_vec_seq #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .aeqb      (aeqb),
        .busy      (busy),
        .done_tick (done_tick),
        .vec_idx   (vec_idx),
        .err_cnt   (err_cnt),
        .pass      (pass)
    );

    task automatic model(input logic [15:0] mask);
        int  first;
        bit  eq_exp;
        bit  cmp_out;
        first   = -1;
        exp_err = 0;
        for (int i = 0; i < 16; i++) begin
            eq_exp  = ((i / 4) == (i % 4));
            cmp_out = eq_exp ^ mask[i];
            if (cmp_out != eq_exp) begin
                if (first < 0) first = i;
                exp_err++;
            end
        end
        exp_last = 15;
        exp_done = 16 * (S + 1) + 1;
`ifdef EQ2_SEQ_STOP_ON_ERR_EN
        if (first >= 0) begin
            exp_err  = 1;
            exp_last = first;
            exp_done = (first + 1) * (S + 1) + 1;
        end
`endif
        if (exp_err > 31) exp_err = 31;
    endtask

    task automatic do_run(input int restart_cycle);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        run_done = -1;
        for (int c = 1; c <= MAXC; c++) begin
            tr_vec[c]  = vec_idx;
            tr_a[c]    = a;
            tr_b[c]    = b;
            tr_busy[c] = busy;
            tr_dt[c]   = done_tick;
            tr_err[c]  = err_cnt;
            tr_pass[c] = pass;
            start = (c == restart_cycle);
            if (done_tick === 1'b1 && run_done < 0) run_done = c;
            if (run_done >= 0 && c == run_done + 1) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        fault_mask = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({a, b, vec_idx, err_cnt, busy, done_tick, pass} !== 16'h0000)
            $display("FAIL reset_values got %h want 0000", {a, b, vec_idx, err_cnt, busy, done_tick, pass});
        else n_pass++;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done_tick, vec_idx, err_cnt} !== 11'd0)
            $display("FAIL idle_without_start got busy=%b dt=%b vec=%0d err=%0d want all 0",
                     busy, done_tick, vec_idx, err_cnt);
        else n_pass++;
    endtask

    task automatic test_run(input string name, input logic [15:0] mask, input int restart);
        int   ev;
        logic exp_busy;
        logic exp_dt;
        logic exp_pass;
        fault_mask = mask;
        model(mask);
        do_run(restart);
        n_checks++;
        if (run_done !== exp_done)
            $display("FAIL %s done_cycle got %0d want %0d", name, run_done, exp_done);
        else n_pass++;
        for (int c = 1; c <= exp_done + 1; c++) begin
            ev = (c - 1) / (S + 1);
            if (ev > exp_last) ev = exp_last;
            exp_busy = (c < exp_done);
            exp_dt   = (c == exp_done);
            exp_pass = (c >= exp_done) ? (exp_err == 0) : 1'b0;
            n_checks++;
            if (tr_vec[c] !== 4'(ev) || tr_a[c] !== 2'(ev / 4) || tr_b[c] !== 2'(ev % 4))
                $display("FAIL %s vector c%0d got vec=%0d a=%0d b=%0d want vec=%0d a=%0d b=%0d",
                         name, c, tr_vec[c], tr_a[c], tr_b[c], ev, ev / 4, ev % 4);
            else n_pass++;
            n_checks++;
            if (tr_busy[c] !== exp_busy || tr_dt[c] !== exp_dt)
                $display("FAIL %s busy_done c%0d got busy=%b dt=%b want busy=%b dt=%b",
                         name, c, tr_busy[c], tr_dt[c], exp_busy, exp_dt);
            else n_pass++;
            n_checks++;
            if (tr_pass[c] !== exp_pass)
                $display("FAIL %s pass c%0d got %b want %b", name, c, tr_pass[c], exp_pass);
            else n_pass++;
        end
        n_checks++;
        if (tr_err[exp_done] !== 5'(exp_err) || tr_err[exp_done + 1] !== 5'(exp_err))
            $display("FAIL %s err_cnt got %0d/%0d want %0d",
                     name, tr_err[exp_done], tr_err[exp_done + 1], exp_err);
        else n_pass++;
    endtask

    task automatic test_random_faults();
        logic [15:0] m;
        for (int k = 0; k < 4; k++) begin
            m = 16'($urandom);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            test_run($sformatf("random_%0d_mask_%h", k, m), m, 0);
        end
    endtask

    task automatic test_reset_mid_run();
        int c;
        fault_mask = 16'h0000;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        c = 0;
        while (vec_idx !== 4'd7 && c < MAXC) begin
            @(posedge clk); #1;
            c++;
        end
        n_checks++;
        if (vec_idx !== 4'd7)
            $display("FAIL reach_vec7 got %0d want 7", vec_idx);
        else n_pass++;
        #3 reset = 1'b1;
        #1;
        n_checks++;
        if ({a, b, vec_idx, err_cnt, busy, done_tick, pass} !== 16'h0000)
            $display("FAIL async_reset got %h want 0000", {a, b, vec_idx, err_cnt, busy, done_tick, pass});
        else n_pass++;
        @(posedge clk); #4 reset = 1'b0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_tick !== 1'b0 || busy !== 1'b0) c++;
        end
        n_checks++;
        if (c !== 0)
            $display("FAIL reset_no_done got %0d bad cycles want 0", c);
        else n_pass++;
        test_run("post_reset_clean", 16'h0000, 0);
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        fault_mask = 16'h0000;
        model(fault_mask);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1;
        first_done  = -1;
        second_done = -1;
        for (int c = 1; c <= 2 * MAXC; c++) begin
            if (c == exp_done + 1) begin
                n_checks++;
                if (busy !== 1'b0 || done_tick !== 1'b0 || pass !== 1'b1 || vec_idx !== 4'(exp_last))
                    $display("FAIL b2b_idle_cycle got busy=%b dt=%b pass=%b vec=%0d want 0 0 1 %0d",
                             busy, done_tick, pass, vec_idx, exp_last);
                else n_pass++;
            end
            if (c == exp_done + 2) begin
                n_checks++;
                if (busy !== 1'b1 || vec_idx !== 4'd0 || err_cnt !== 5'd0 || pass !== 1'b0)
                    $display("FAIL b2b_restart got busy=%b vec=%0d err=%0d pass=%b want 1 0 0 0",
                             busy, vec_idx, err_cnt, pass);
                else n_pass++;
                start = 1'b0;
            end
            if (done_tick === 1'b1) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (second_done >= 0) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_checks++;
        if (first_done !== exp_done || second_done !== 2 * exp_done + 1)
            $display("FAIL b2b_done_cycles got %0d,%0d want %0d,%0d",
                     first_done, second_done, exp_done, 2 * exp_done + 1);
        else n_pass++;
        n_checks++;
        if (err_cnt !== 5'd0 || pass !== 1'b1)
            $display("FAIL b2b_result got err=%0d pass=%b want 0 1", err_cnt, pass);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run("correct_eq2", 16'h0000, 0);
        test_run("stuck_at_0", 16'h8421, 0);
        test_run("stuck_at_1", 16'h7bde, 0);
        test_run("restart_ignored", 16'h0000, 30);
        test_random_faults();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
